// File: rtl/signed_vector_acc_mc.sv
// Multi-lane signed vector accumulator backed by a single-port-per-direction BRAM.
// Sums acc_len consecutive vectors bin-by-bin and emits the integrated vector once per integration.
module signed_vector_acc_mc #(
    parameter int DIN_WIDTH     = 18,
    parameter int DOUT_WIDTH    = 48,
    parameter int VECTOR_LEN    = 1024,
    parameter int PARALLEL      = 4,
    parameter int ACC_LEN_WIDTH = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_sync,
    input  logic [ACC_LEN_WIDTH-1:0]       i_acc_len,
    input  logic [PARALLEL*DIN_WIDTH-1:0]  i_din,
    input  logic                           i_din_valid,
    output logic [PARALLEL*DOUT_WIDTH-1:0] o_dout,
    output logic                           o_dout_valid,
    output logic                           o_dout_last,
    output logic                           o_ovf
);

    localparam int WORDS = VECTOR_LEN / PARALLEL;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    logic [AW-1:0]                   r_addr;
    logic [ACC_LEN_WIDTH-1:0]        r_vecCnt;
    logic [ACC_LEN_WIDTH-1:0]        r_accLen;

    logic                            r_s1Valid;
    logic                            r_s1First;
    logic                            r_s1Last;
    logic [AW-1:0]                   r_s1Addr;
    logic [PARALLEL*DIN_WIDTH-1:0]   r_s1Din;

    logic [PARALLEL*DOUT_WIDTH-1:0]  r_bram [WORDS];
    logic [PARALLEL*DOUT_WIDTH-1:0]  r_bramQ;

    logic                            w_intStart;
    logic [ACC_LEN_WIDTH-1:0]        w_len;
    logic                            w_isFirst;
    logic                            w_isLast;

    logic [PARALLEL*DOUT_WIDTH-1:0]  w_sum;
    logic                            w_anyOvf;
    logic signed [DOUT_WIDTH-1:0]    w_inExt;
    logic signed [DOUT_WIDTH-1:0]    w_acc;
    logic signed [DOUT_WIDTH-1:0]    w_laneSum;

    // acc_len is taken live on the first word of an integration, from the latched copy afterwards.
    assign w_intStart = (r_vecCnt == '0) && (r_addr == '0);
    assign w_len      = w_intStart ? i_acc_len : r_accLen;
    assign w_isFirst  = (r_vecCnt == '0);
    assign w_isLast   = (w_len <= ACC_LEN_WIDTH'(1)) ||
                        (r_vecCnt == (w_len - ACC_LEN_WIDTH'(1)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr   <= '0;
            r_vecCnt <= '0;
            r_accLen <= '0;
        end else begin
            if (i_din_valid) begin
                if (w_intStart) begin
                    r_accLen <= i_acc_len;
                end
                if (r_addr == LAST_ADDR) begin
                    r_addr   <= '0;
                    r_vecCnt <= w_isLast ? '0 : r_vecCnt + ACC_LEN_WIDTH'(1);
                end else begin
                    r_addr <= r_addr + AW'(1);
                end
            end
            // A sync overrides the normal advance, after any coincident word has been processed.
            if (i_sync) begin
                r_addr   <= '0;
                r_vecCnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1Valid <= 1'b0;
        end else begin
            r_s1Valid <= i_din_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_din_valid) begin
            r_s1First <= w_isFirst;
            r_s1Last  <= w_isLast;
            r_s1Addr  <= r_addr;
            r_s1Din   <= i_din;
        end
    end

    // Read at the input address while the previous word is written; addresses never collide.
    always_ff @(posedge i_clk) begin
        if (i_din_valid) begin
            r_bramQ <= r_bram[r_addr];
        end
        if (r_s1Valid) begin
            r_bram[r_s1Addr] <= w_sum;
        end
    end

    always_comb begin
        w_sum     = '0;
        w_anyOvf  = 1'b0;
        w_inExt   = '0;
        w_acc     = '0;
        w_laneSum = '0;
        for (int k = 0; k < PARALLEL; k++) begin
            w_inExt   = DOUT_WIDTH'($signed(r_s1Din[k*DIN_WIDTH +: DIN_WIDTH]));
            w_acc     = $signed(r_bramQ[k*DOUT_WIDTH +: DOUT_WIDTH]);
            w_laneSum = w_acc + w_inExt;
            if (r_s1First) begin
                w_sum[k*DOUT_WIDTH +: DOUT_WIDTH] = w_inExt;
            end else begin
                w_sum[k*DOUT_WIDTH +: DOUT_WIDTH] = w_laneSum;
                if ((w_acc[DOUT_WIDTH-1] == w_inExt[DOUT_WIDTH-1]) &&
                    (w_laneSum[DOUT_WIDTH-1] != w_acc[DOUT_WIDTH-1])) begin
                    w_anyOvf = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dout       <= '0;
            o_dout_valid <= 1'b0;
            o_dout_last  <= 1'b0;
            o_ovf        <= 1'b0;
        end else begin
            o_dout_valid <= r_s1Valid && r_s1Last;
            o_dout_last  <= r_s1Valid && r_s1Last && (r_s1Addr == LAST_ADDR);
            if (r_s1Valid && r_s1Last) begin
                o_dout <= w_sum;
            end
            if (r_s1Valid && w_anyOvf) begin
                o_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_signed_vector_acc_mc.sv
// Directed bench for signed_vector_acc_mc: a wide instance for the arithmetic and framing,
// and a narrow 8-bit instance sharing the same controls for wrap-around and overflow.
module tb_signed_vector_acc_mc;

    localparam int DIN_A  = 18;
    localparam int DOUT_A = 48;
    localparam int DIN_B  = 8;
    localparam int DOUT_B = 8;
    localparam int VL     = 16;
    localparam int P      = 4;
    localparam int ALW    = 16;
    localparam int WORDS  = VL / P;

    logic               clk = 1'b0;
    logic               rst;
    logic               syncIn;
    logic               dinValid;
    logic [ALW-1:0]     accLen;
    logic [P*DIN_A-1:0] dinA;
    logic [P*DIN_B-1:0] dinB;

    logic [P*DOUT_A-1:0] doutA;
    logic                doutValidA, doutLastA, ovfA;
    logic [P*DOUT_B-1:0] doutB;
    logic                doutValidB, doutLastB, ovfB;

    int cycleCount = 0;
    int checkCount = 0;
    int errorCount = 0;
    int wordCycle [WORDS];
    int refCycle  [WORDS];

    logic [P*DOUT_A-1:0] qDataA [$];
    bit                  qLastA [$];
    int                  qCycA  [$];
    logic [P*DOUT_B-1:0] qDataB [$];

    signed_vector_acc_mc #(
        .DIN_WIDTH(DIN_A), .DOUT_WIDTH(DOUT_A), .VECTOR_LEN(VL),
        .PARALLEL(P), .ACC_LEN_WIDTH(ALW)
    ) dutA (
        .i_clk(clk), .i_rst(rst), .i_sync(syncIn), .i_acc_len(accLen),
        .i_din(dinA), .i_din_valid(dinValid),
        .o_dout(doutA), .o_dout_valid(doutValidA), .o_dout_last(doutLastA), .o_ovf(ovfA)
    );

    signed_vector_acc_mc #(
        .DIN_WIDTH(DIN_B), .DOUT_WIDTH(DOUT_B), .VECTOR_LEN(VL),
        .PARALLEL(P), .ACC_LEN_WIDTH(ALW)
    ) dutB (
        .i_clk(clk), .i_rst(rst), .i_sync(syncIn), .i_acc_len(accLen),
        .i_din(dinB), .i_din_valid(dinValid),
        .o_dout(doutB), .o_dout_valid(doutValidB), .o_dout_last(doutLastB), .o_ovf(ovfB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Collect every output word on the falling edge, away from the register updates.
    always @(negedge clk) begin
        if (doutValidA) begin
            qDataA.push_back(doutA);
            qLastA.push_back(doutLastA);
            qCycA.push_back(cycleCount);
        end
        if (doutValidB) begin
            qDataB.push_back(doutB);
        end
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint laneA(input logic [P*DOUT_A-1:0] w, input int k);
        logic signed [DOUT_A-1:0] t;
        t = w[k*DOUT_A +: DOUT_A];
        return longint'(t);
    endfunction

    function automatic longint laneB(input logic [P*DOUT_B-1:0] w, input int k);
        logic signed [DOUT_B-1:0] t;
        t = w[k*DOUT_B +: DOUT_B];
        return longint'(t);
    endfunction

    // mode 0: every lane carries value; mode 1: lane carries -(bin index)
    function automatic int laneValue(input int mode, input int value, input int bin);
        return (mode == 0) ? value : -bin;
    endfunction

    task automatic applyStimulus(input logic valid, input logic syncBit,
                                 input int wordIdx, input int mode, input int value);
        int v;
        dinValid = valid;
        syncIn   = syncBit;
        for (int k = 0; k < P; k++) begin
            v = laneValue(mode, value, wordIdx * P + k);
            dinA[k*DIN_A +: DIN_A] = DIN_A'(v);
            dinB[k*DIN_B +: DIN_B] = DIN_B'(v);
        end
        @(posedge clk);
        #1;
        dinValid = 1'b0;
        syncIn   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic sendVector(input int mode, input int value, input int gap);
        for (int w = 0; w < WORDS; w++) begin
            wordCycle[w] = cycleCount;
            applyStimulus(1'b1, 1'b0, w, mode, value);
            idle(gap);
        end
    endtask

    task automatic clearQueues();
        qDataA.delete();
        qLastA.delete();
        qCycA.delete();
        qDataB.delete();
    endtask

    task automatic checkConstVectors(input string tag, input int nWords, input longint value);
        checkOutput({tag, "_count"}, qDataA.size(), nWords);
        for (int i = 0; i < nWords && i < qDataA.size(); i++) begin
            for (int k = 0; k < P; k++) begin
                checkOutput({tag, "_lane"}, laneA(qDataA[i], k), value);
            end
            checkOutput({tag, "_last"}, qLastA[i], ((i % WORDS) == WORDS - 1) ? 1 : 0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        syncIn   = 1'b0;
        dinValid = 1'b0;
        accLen   = '0;
        dinA     = '0;
        dinB     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", doutValidA, 0);
        checkOutput("rst_last", doutLastA, 0);
        checkOutput("rst_ovf", ovfA, 0);
        checkOutput("rst_dout", (doutA == '0) ? 1 : 0, 1);
        checkOutput("rst_doutB", (doutB == '0) ? 1 : 0, 1);
        rst = 1'b0;
        idle(2);

        // Constant +3, acc_len 4, continuous: two integrations of 12s.
        clearQueues();
        accLen = 16'd4;
        applyStimulus(1'b0, 1'b1, 0, 0, 0);
        for (int v = 0; v < 8; v++) begin
            sendVector(0, 3, 0);
            if (v == 3) refCycle = wordCycle;
        end
        idle(4);
        checkConstVectors("const", 8, 12);
        if (qCycA.size() >= 5) begin
            checkOutput("const_lat_first", qCycA[0] - refCycle[0], 2);
            checkOutput("const_lat_last", qCycA[3] - refCycle[3], 2);
            checkOutput("const_period", qCycA[4] - qCycA[0], 16);
        end

        // Signed ramp, acc_len 3: bin b integrates to -3b.
        clearQueues();
        accLen = 16'd3;
        applyStimulus(1'b0, 1'b1, 0, 0, 0);
        repeat (3) sendVector(1, 0, 0);
        idle(4);
        checkOutput("ramp_count", qDataA.size(), WORDS);
        for (int w = 0; w < WORDS && w < qDataA.size(); w++) begin
            for (int k = 0; k < P; k++) begin
                checkOutput("ramp_lane", laneA(qDataA[w], k), -3 * (w * P + k));
            end
        end

        // Gapped input: one valid word in three.
        clearQueues();
        accLen = 16'd4;
        applyStimulus(1'b0, 1'b1, 0, 0, 0);
        repeat (4) sendVector(0, 3, 2);
        idle(4);
        checkConstVectors("gap", 4, 12);

        // Sync two words into the second vector aborts; next integration of 5s sums to 20.
        clearQueues();
        accLen = 16'd4;
        applyStimulus(1'b0, 1'b1, 0, 0, 0);
        sendVector(0, 3, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 3);
        applyStimulus(1'b1, 1'b0, 1, 0, 3);
        applyStimulus(1'b0, 1'b1, 0, 0, 0);
        repeat (4) sendVector(0, 5, 0);
        idle(4);
        checkConstVectors("resync", 4, 20);

        // acc_len 1 echoes; switching to 2 mid-vector applies from the next integration.
        clearQueues();
        accLen = 16'd1;
        applyStimulus(1'b0, 1'b1, 0, 0, 0);
        sendVector(1, 0, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 7);
        applyStimulus(1'b1, 1'b0, 1, 0, 7);
        accLen = 16'd2;
        applyStimulus(1'b1, 1'b0, 2, 0, 7);
        applyStimulus(1'b1, 1'b0, 3, 0, 7);
        sendVector(0, 1, 0);
        sendVector(0, 2, 0);
        idle(4);
        checkOutput("len_count", qDataA.size(), 3 * WORDS);
        for (int i = 0; i < 3 * WORDS && i < qDataA.size(); i++) begin
            for (int k = 0; k < P; k++) begin
                checkOutput("len_lane", laneA(qDataA[i], k),
                            (i < WORDS) ? -(i * P + k) : (i < 2 * WORDS) ? 7 : 3);
            end
        end

        // Overflow on the 8-bit instance: 100 + 100 wraps to -56.
        checkOutput("ovf_pre", ovfB, 0);
        clearQueues();
        accLen = 16'd2;
        applyStimulus(1'b0, 1'b1, 0, 0, 0);
        repeat (2) sendVector(0, 100, 0);
        idle(4);
        checkOutput("ovf_count", qDataB.size(), WORDS);
        for (int i = 0; i < WORDS && i < qDataB.size(); i++) begin
            for (int k = 0; k < P; k++) begin
                checkOutput("ovf_wrap", laneB(qDataB[i], k), -56);
            end
        end
        checkConstVectors("wide200", 4, 200);
        checkOutput("ovf_set", ovfB, 1);
        checkOutput("ovf_wide_clear", ovfA, 0);
        idle(3);
        checkOutput("ovf_sticky", ovfB, 1);

        // Reset while output words are streaming.
        applyStimulus(1'b0, 1'b1, 0, 0, 0);
        sendVector(0, 100, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 100);
        applyStimulus(1'b1, 1'b0, 1, 0, 100);
        checkOutput("mid_valid", doutValidB, 1);
        checkOutput("mid_ovf", ovfB, 1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 0, 0);
        checkOutput("rst2_valid", doutValidB, 0);
        checkOutput("rst2_ovf", ovfB, 0);
        checkOutput("rst2_dout", (doutB == '0) ? 1 : 0, 1);
        rst = 1'b0;
        idle(4);
        checkOutput("rst2_dropped", doutValidB, 0);
        checkOutput("rst2_ovf_hold", ovfB, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/signed_vector_acc_mc.md
Name: signed_vector_acc_mc

Overview:
- Multi-lane, signed, BRAM-backed vector accumulator for the spectral/correlator post-processing chain.
- Accepts PARALLEL consecutive vector bins per cycle and sums ACC_LEN consecutive vectors bin-by-bin.
- Emits the integrated vector once per integration, with frame-last and overflow flags.
- Successor to the single-lane accumulator: adds lanes, runtime integration length, sync alignment, synchronous reset and overflow detection.

Parameters:
- DIN_WIDTH, 18: signed width of one input lane.
- DOUT_WIDTH, 48: signed width of one accumulator lane; must be at least DIN_WIDTH.
- VECTOR_LEN, 1024: bins per vector; power of two.
- PARALLEL, 4: lanes per word; power of two; VECTOR_LEN/PARALLEL must be at least 4.
- ACC_LEN_WIDTH, 16: width of the acc_len input.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- sync, input, 1: one-cycle pulse marking the word before the first word of a vector.
- acc_len, input, ACC_LEN_WIDTH: number of vectors per integration, unsigned.
- din, input, PARALLEL*DIN_WIDTH: lane k occupies bits [k*DIN_WIDTH +: DIN_WIDTH]; each lane is signed.
- din_valid, input, 1: din qualifier.
- dout, output, PARALLEL*DOUT_WIDTH: integrated lanes, same packing as din.
- dout_valid, output, 1: dout qualifier.
- dout_last, output, 1: high with the final word of an output vector.
- ovf, output, 1: sticky overflow flag.

Behaviour:
- Reset (synchronous, active-high):
  - dout_valid, dout_last, ovf and dout are 0.
  - Word address = 0 and vector counter = 0; the next vector is treated as the first of an integration.
  - BRAM contents are don't-care, because the first vector always overwrites.
- Addressing:
  - Word address counts din_valid words from 0 to VECTOR_LEN/PARALLEL-1 and wraps to 0.
  - Bin index = address*PARALLEL + lane.
  - Gaps in din_valid stall the pipeline without loss.
- Sync:
  - sync forces the address to 0 for the next valid word.
  - It also restarts the integration: vector counter = 0, first-vector mode.
  - A partial integration is discarded and no output is produced for it.
  - sync coincident with din_valid: that word is processed as the last word of the current address sequence, then the restart takes effect.
- Integration length:
  - acc_len is sampled on the first word of each integration; changes mid-integration are ignored.
  - acc_len of 0 or 1 means every vector passes straight through with dout = din sign-extended.
- Arithmetic:
  - Each lane is sign-extended to DOUT_WIDTH.
  - First vector of an integration: BRAM is written with the input value.
  - Later vectors: BRAM is written with bram_out + input, two's-complement wrap.
  - Last vector: the sum is driven on dout and the BRAM is also written.
- Overflow:
  - ovf sets when any lane addition has its operand signs equal and the result sign different.
  - ovf stays set until rst.
- Latency and pipeline:
  - Fixed 2 cycles from din_valid to dout_valid, through BRAM read then add/register.
  - Read address leads write address so back-to-back din_valid at full rate is hazard-free.
  - Requires VECTOR_LEN/PARALLEL ≥ 4.
- Output framing:
  - dout_valid is high for exactly VECTOR_LEN/PARALLEL words per integration, in address order.
  - dout_last accompanies address VECTOR_LEN/PARALLEL-1.
  - dout is held between valid words.
- rst mid-integration: same as reset, and any in-flight output words are dropped.

Test Plan:
- Constant input, full rate: VECTOR_LEN=16, PARALLEL=4, acc_len=4, every lane = +3, din_valid continuous after sync.
  - dout_valid on 4 words every 16 words; every lane = 12; dout_last on the 4th word.
  - First dout_valid 2 cycles after the last input word's din_valid.
- Signed ramp: lane value = −(bin index), acc_len=3.
  - Output bin b = −3b, for b = 0..15; verifies sign extension and lane packing.
- Gapped input: same as the constant case but din_valid high 1 cycle in 3.
  - Identical output values; dout_valid count = 4 per integration.
- Mid-vector sync: sync asserted after 2 words of the 2nd vector.
  - No output for the aborted integration.
  - Next full integration of acc_len vectors yields the correct sum, with no stale BRAM contribution.
- acc_len change and pass-through: acc_len=1, then changed to 2 mid-integration.
  - Each vector is echoed unchanged; the new length takes effect only at the next integration start.
- Overflow: DOUT_WIDTH=DIN_WIDTH=8, input +100, acc_len=2.
  - Output lanes = −56 (wrap); ovf rises and stays 1; rst clears ovf and dout_valid on the next edge.
